uart_rx_msg: RTL and testbench

Parses the host-to-FPGA command stream arriving byte-wise from the UART receiver, validates the header and CRC8, and drives the CORDIC operand path and the `uart_tx_msg` control inputs. It sits between `uart_rx` and both `cordic` and `uart_tx_msg`. It also holds the CORDIC enable state toggled by the DISABLE and ENABLE commands.

---
 rtl/pkg_msg.sv | 33 +++
 rtl/uart_rx_msg.sv | 159 +++++++++++++++
 tb/tb_uart_rx_msg.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkg_msg.sv
// Host command protocol constants, CRC8 step and
// the receive parser state encoding.
package pkg_msg;

  localparam logic [7:0] BYTE_HEADER      = 8'hA5;
  localparam logic [7:0] CMD_SINGLE_TRANS = 8'h01;
  localparam logic [7:0] CMD_BURST_TRANS  = 8'h02;
  localparam logic [7:0] CMD_DISABLE      = 8'h03;
  localparam logic [7:0] CMD_ENABLE       = 8'h04;
  localparam logic [7:0] POLY             = 8'h07;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_BURST_CNT,
    S_OPERAND,
    S_CRC
  } rx_msg_state_t;

  function automatic logic [7:0] crc8_byte(
    input logic [7:0] crc,
    input logic [7:0] data
  );
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ POLY;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_msg.sv
// Command frame parser: header, cmd, payload, CRC8.
// Streams operands out before the CRC is verified.
module uart_rx_msg
  import pkg_msg::*;
#(
  parameter int THETA_BYTES    = 6,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_rx_byte,
  input  logic                     i_rx_byte_valid,
  output logic [7:0]               o_cmd_reg,
  output logic                     o_cmd_valid,
  output logic [7:0]               o_burst_cnt,
  output logic                     o_burst_cnt_valid,
  output logic [8*THETA_BYTES-1:0] o_theta,
  output logic                     o_theta_valid,
  output logic                     o_cordic_en,
  output logic                     o_msg_ok,
  output logic                     o_rx_msg_err
);

  localparam int TW = 8 * THETA_BYTES;
  localparam int SW = TW - 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int KW = (THETA_BYTES > 1) ?
                      $clog2(THETA_BYTES) : 1;

  rx_msg_state_t state;
  logic [7:0]    crc;
  logic [7:0]    remain;
  logic [KW-1:0] k;
  logic [SW-1:0] sh;
  logic [CW-1:0] tmo;
  logic [7:0]    crc_nxt;
  logic          known;
  logic          tmo_hit;
  logic          err;

  assign crc_nxt = crc8_byte(crc, i_rx_byte);

  always_comb begin
    known = 1'b0;
    unique case (1'b1)
      i_rx_byte == CMD_SINGLE_TRANS: known = 1'b1;
      i_rx_byte == CMD_BURST_TRANS:  known = 1'b1;
      i_rx_byte == CMD_DISABLE:      known = 1'b1;
      i_rx_byte == CMD_ENABLE:       known = 1'b1;
      default:                       known = 1'b0;
    endcase
  end

  // A byte in the expiry cycle wins, so the hit needs no strobe.
  assign tmo_hit = (state != S_IDLE) && !i_rx_byte_valid &&
                   (tmo == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    err = tmo_hit;
    if (i_rx_byte_valid) begin
      unique case (state)
        S_CMD:       err = !known;
        S_BURST_CNT: err = (i_rx_byte == 8'd0);
        S_CRC:       err = (i_rx_byte != crc);
        default:     err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= S_IDLE;
      crc               <= '0;
      remain            <= '0;
      k                 <= '0;
      sh                <= '0;
      tmo               <= '0;
      o_cmd_reg         <= '0;
      o_cmd_valid       <= 1'b0;
      o_burst_cnt       <= '0;
      o_burst_cnt_valid <= 1'b0;
      o_theta           <= '0;
      o_theta_valid     <= 1'b0;
      o_cordic_en       <= 1'b1;
      o_msg_ok          <= 1'b0;
      o_rx_msg_err      <= 1'b0;
    end else begin
      o_cmd_valid       <= 1'b0;
      o_burst_cnt_valid <= 1'b0;
      o_theta_valid     <= 1'b0;
      o_msg_ok          <= 1'b0;
      o_rx_msg_err      <= 1'b0;
      if (i_rx_byte_valid || state == S_IDLE) tmo <= '0;
      else                                    tmo <= tmo + 1'b1;
      if (err) begin
        o_rx_msg_err <= 1'b1;
        state        <= S_IDLE;
        crc          <= '0;
        remain       <= '0;
        k            <= '0;
        tmo          <= '0;
      end else if (i_rx_byte_valid) begin
        unique case (state)
          S_IDLE: begin
            if (i_rx_byte == BYTE_HEADER) begin
              crc   <= crc8_byte(8'h00, i_rx_byte);
              state <= S_CMD;
            end
          end
          S_CMD: begin
            crc         <= crc_nxt;
            k           <= '0;
            o_cmd_reg   <= i_rx_byte;
            o_cmd_valid <= 1'b1;
            unique case (1'b1)
              i_rx_byte == CMD_SINGLE_TRANS: begin
                remain <= 8'd1;
                state  <= S_OPERAND;
              end
              i_rx_byte == CMD_BURST_TRANS:
                state <= S_BURST_CNT;
              default:
                state <= S_CRC;
            endcase
          end
          S_BURST_CNT: begin
            crc               <= crc_nxt;
            remain            <= i_rx_byte;
            o_burst_cnt       <= i_rx_byte;
            o_burst_cnt_valid <= 1'b1;
            state             <= S_OPERAND;
          end
          S_OPERAND: begin
            crc <= crc_nxt;
            sh  <= SW'({i_rx_byte, sh} >> 8);
            if (k == KW'(THETA_BYTES - 1)) begin
              k             <= '0;
              o_theta       <= {i_rx_byte, sh};
              o_theta_valid <= 1'b1;
              remain        <= remain - 1'b1;
              if (remain == 8'd1) state <= S_CRC;
            end else begin
              k <= k + 1'b1;
            end
          end
          S_CRC: begin
            o_msg_ok <= 1'b1;
            crc      <= '0;
            state    <= S_IDLE;
            if (o_cmd_reg == CMD_DISABLE) o_cordic_en <= 1'b0;
            if (o_cmd_reg == CMD_ENABLE)  o_cordic_en <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_msg.sv
// Scoreboard bench for uart_rx_msg: directed frames,
// expected pulses queued with value and arrival cycle.
module tb_uart_rx_msg;
  import pkg_msg::*;

  localparam int TB   = 6;
  localparam int TMO  = 40;
  localparam int K_CMD = 0;
  localparam int K_BCNT = 1;
  localparam int K_TH = 2;
  localparam int K_OK = 3;
  localparam int K_ERR = 4;

  typedef struct {
    int          kind;
    logic [47:0] val;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  cmd_reg;
  logic        cmd_valid;
  logic [7:0]  bcnt;
  logic        bcnt_valid;
  logic [47:0] theta;
  logic        theta_valid;
  logic        cordic_en;
  logic        msg_ok;
  logic        msg_err;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  logic [7:0] crc_tb = 8'h00;

  uart_rx_msg #(
    .THETA_BYTES(TB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx_byte(rx_byte),
    .i_rx_byte_valid(rx_valid),
    .o_cmd_reg(cmd_reg),
    .o_cmd_valid(cmd_valid),
    .o_burst_cnt(bcnt),
    .o_burst_cnt_valid(bcnt_valid),
    .o_theta(theta),
    .o_theta_valid(theta_valid),
    .o_cordic_en(cordic_en),
    .o_msg_ok(msg_ok),
    .o_rx_msg_err(msg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] crc_ref(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_CMD:   return "cmd";
      K_BCNT:  return "burst_cnt";
      K_TH:    return "theta";
      K_OK:    return "msg_ok";
      default: return "msg_err";
    endcase
  endfunction

  task automatic chk_ev(input int kind, input logic [47:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s got=%h at cyc %0d",
               kname(kind), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != v || e.cyc != cyc) begin
        failures++;
        $display("FAIL ev_%s got %s=%h cyc=%0d need %s=%h cyc=%0d",
                 kname(e.kind), kname(kind), v, cyc,
                 kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid)   chk_ev(K_CMD, {40'h0, cmd_reg});
      if (bcnt_valid)  chk_ev(K_BCNT, {40'h0, bcnt});
      if (theta_valid) chk_ev(K_TH, theta);
      if (msg_ok)      chk_ev(K_OK, 48'h0);
      if (msg_err)     chk_ev(K_ERR, 48'h0);
    end
  end

  task automatic chk(input string nm, input logic [47:0] got,
                     input logic [47:0] need);
    checks++;
    if (got !== need) begin
      failures++;
      $display("FAIL %s got=%h need=%h", nm, got, need);
    end
  endtask

  task automatic pb(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    last_cyc = cyc;
    crc_tb   = crc_ref(crc_tb, b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic exp_ev(input int kind, input logic [47:0] v,
                        input int lat);
    exp_q.push_back('{kind: kind, val: v, cyc: last_cyc + lat});
  endtask

  task automatic hdr;
    crc_tb = 8'h00;
    pb(BYTE_HEADER);
  endtask

  task automatic cmd(input logic [7:0] c);
    pb(c);
    exp_ev(K_CMD, {40'h0, c}, 1);
  endtask

  task automatic operand(input logic [47:0] v, input bit gap);
    for (int i = 0; i < TB; i++) begin
      pb(v[8*i +: 8]);
      if (gap) idle(1);
    end
    exp_ev(K_TH, v, 1);
  endtask

  task automatic tail(input logic [7:0] mask);
    logic [7:0] c;
    c = crc_tb ^ mask;
    pb(c);
    exp_ev(mask == 8'h00 ? K_OK : K_ERR, 48'h0, 1);
    idle(2);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_reg"}, {40'h0, cmd_reg}, 48'h0);
    chk({tag, "_burst_cnt"}, {40'h0, bcnt}, 48'h0);
    chk({tag, "_theta"}, theta, 48'h0);
    chk({tag, "_cordic_en"}, {47'h0, cordic_en}, 48'h1);
    chk({tag, "_pulses"},
        {43'h0, cmd_valid, bcnt_valid, theta_valid,
         msg_ok, msg_err}, 48'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d need finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk_reset("rst");
    rst = 1'b0;
    idle(2);

    hdr();
    cmd(CMD_SINGLE_TRANS);
    operand(48'h0000_1234_5678, 1'b0);
    tail(8'h00);

    hdr();
    cmd(CMD_BURST_TRANS);
    pb(8'd3);
    exp_ev(K_BCNT, 48'd3, 1);
    operand(48'd1, 1'b0);
    operand(48'd2, 1'b0);
    operand(48'd3, 1'b1);
    tail(8'h00);
    chk("theta_held", theta, 48'd3);

    hdr();
    cmd(CMD_DISABLE);
    tail(8'h00);
    chk("en_after_disable", {47'h0, cordic_en}, 48'h0);
    hdr();
    cmd(CMD_ENABLE);
    tail(8'h00);
    chk("en_after_enable", {47'h0, cordic_en}, 48'h1);

    hdr();
    cmd(CMD_DISABLE);
    tail(8'h01);
    chk("en_after_bad_crc", {47'h0, cordic_en}, 48'h1);
    hdr();
    cmd(CMD_SINGLE_TRANS);
    operand(48'hA5A5_0000_00A5, 1'b1);
    tail(8'h00);

    pb(8'h00);
    pb(8'hFF);
    idle(2);
    hdr();
    pb(8'h7E);
    exp_ev(K_ERR, 48'h0, 1);
    idle(3);
    chk("cmd_held_unknown", {40'h0, cmd_reg},
        {40'h0, CMD_SINGLE_TRANS});

    hdr();
    cmd(CMD_SINGLE_TRANS);
    pb(8'h11);
    pb(8'h22);
    exp_ev(K_ERR, 48'h0, 1 + TMO);
    idle(TMO + 5);

    hdr();
    cmd(CMD_DISABLE);
    tail(8'h00);
    chk("en_before_rst", {47'h0, cordic_en}, 48'h0);
    hdr();
    cmd(CMD_SINGLE_TRANS);
    pb(8'h33);
    pb(8'h44);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    idle(2);

    hdr();
    cmd(CMD_SINGLE_TRANS);
    operand(48'h0102_0304_0506, 1'b0);
    tail(8'h00);

    idle(5);
    chk("queue_drained", 48'(exp_q.size()), 48'h0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
